// File: rtl/moore_detector_1010_pkg.sv
// Shared types and constants for the serial 1-0-1-0 Moore detector.
package moore_detector_1010_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned PATTERN_LEN = 4;
  localparam logic [PATTERN_LEN-1:0] PATTERN = 4'b1010;

  // State name records how much of PATTERN has been matched so far.
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

endpackage

// File: rtl/moore_detector_1010.sv
// Moore detector for serial pattern 1-0-1-0; out is decoded only from the state register.
module moore_detector_1010
  import moore_detector_1010_pkg::*;
#(
  parameter int unsigned OVERLAP = 1
) (
  input  logic in_bit,
  input  logic clk,
  input  logic reset,
  output logic out
);

  state_e state_q;
  state_e state_d;

  // State register; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; illegal encodings fall back to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in_bit ? S1 : S0;
      S1:      state_d = in_bit ? S1 : S2;
      S2:      state_d = in_bit ? S3 : S0;
      S3:      state_d = in_bit ? S1 : S4;
      S4:      state_d = in_bit ? ((OVERLAP != 0) ? S3 : S1) : S0;
      default: state_d = S0;
    endcase
  end

  // Output decode.
  assign out = (state_q == S4);

endmodule

// File: tb/tb_moore_detector_1010.sv
// Self-checking bench: two detectors (overlap / no-overlap) against a sliding-window reference model.
module tb_moore_detector_1010;
  import moore_detector_1010_pkg::*;

  logic clk;
  logic reset;
  logic in_bit;
  logic out_ov;
  logic out_no;

  int vectors;
  int miscompares;

  // Reference history: bits since last restart (overlap keeps a window, no-overlap clears on match).
  bit h_ov[$];
  bit h_no[$];
  state_e st_of[5] = '{S0, S1, S2, S3, S4};

  moore_detector_1010 #(.OVERLAP(1)) u_ov (
    .in_bit(in_bit), .clk(clk), .reset(reset), .out(out_ov)
  );
  moore_detector_1010 #(.OVERLAP(0)) u_no (
    .in_bit(in_bit), .clk(clk), .reset(reset), .out(out_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Longest suffix of the history that equals a prefix of the pattern.
  function automatic int match_len(input bit h[$]);
    logic [3:0] pat;
    bit ok;
    pat = PATTERN;
    for (int k = 4; k >= 1; k--) begin
      if (h.size() >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[h.size() - k + i] != pat[3 - i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    h_ov.delete();
    h_no.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one bit on the falling edge, sample just after the rising edge, advance the model.
  task automatic apply_bit(input bit b, output bit e_ov, output bit e_no,
                           output state_e s_ov, output state_e s_no);
    int ml;
    @(negedge clk);
    in_bit = b;
    @(posedge clk);
    #1;
    h_ov.push_back(b);
    if (h_ov.size() > 4) void'(h_ov.pop_front());
    h_no.push_back(b);
    if (h_no.size() > 4) void'(h_no.pop_front());
    ml   = match_len(h_ov);
    e_ov = (ml == 4);
    s_ov = st_of[ml];
    ml   = match_len(h_no);
    e_no = (ml == 4);
    s_no = st_of[ml];
    if (ml == 4) h_no.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    in_bit = 1'b0;
    #1;
    vectors++;
    if (out_ov !== 1'b0 || u_ov.state_q !== S0) begin
      miscompares++;
      $display("FAIL reset_immediate: out=%b state=%0d, want out=0 state=0", out_ov, u_ov.state_q);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_bit = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      vectors++;
      if (out_ov !== 1'b0 || out_no !== 1'b0 || u_ov.state_q !== S0 || u_no.state_q !== S0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: out_ov=%b out_no=%b st_ov=%0d st_no=%0d, want all 0",
                 c, out_ov, out_no, u_ov.state_q, u_no.state_q);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    h_ov.delete();
    h_no.delete();
  endtask

  task automatic test_overlap_stream();
    bit seq[$] = '{1, 1, 1, 0, 1, 0, 1, 0, 1};
    bit want_ov[$] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
    bit want_no[$] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    bit e_ov, e_no;
    state_e s_ov, s_no;
    do_reset();
    foreach (seq[i]) begin
      apply_bit(seq[i], e_ov, e_no, s_ov, s_no);
      vectors++;
      if (out_ov !== want_ov[i] || out_ov !== e_ov || u_ov.state_q !== s_ov) begin
        miscompares++;
        $display("FAIL stream_ov sample %0d: out=%b state=%0d, want out=%b state=%0d",
                 i + 1, out_ov, u_ov.state_q, want_ov[i], s_ov);
      end
      vectors++;
      if (out_no !== want_no[i] || out_no !== e_no || u_no.state_q !== s_no) begin
        miscompares++;
        $display("FAIL stream_no sample %0d: out=%b state=%0d, want out=%b state=%0d",
                 i + 1, out_no, u_no.state_q, want_no[i], s_no);
      end
    end
  endtask

  task automatic test_near_miss();
    bit seq[$] = '{1, 0, 0, 1, 0, 1, 1, 0};
    bit e_ov, e_no;
    state_e s_ov, s_no;
    do_reset();
    foreach (seq[i]) begin
      apply_bit(seq[i], e_ov, e_no, s_ov, s_no);
      vectors++;
      if (out_ov !== 1'b0 || out_no !== 1'b0 || u_ov.state_q !== s_ov || u_no.state_q !== s_no) begin
        miscompares++;
        $display("FAIL near_miss sample %0d: out_ov=%b out_no=%b st_ov=%0d st_no=%0d, want 0 0 %0d %0d",
                 i + 1, out_ov, out_no, u_ov.state_q, u_no.state_q, s_ov, s_no);
      end
    end
  endtask

  task automatic test_reset_mid_pattern();
    bit seq[$] = '{1, 0, 1};
    bit e_ov, e_no;
    state_e s_ov, s_no;
    do_reset();
    foreach (seq[i]) apply_bit(seq[i], e_ov, e_no, s_ov, s_no);
    vectors++;
    if (u_ov.state_q !== S3) begin
      miscompares++;
      $display("FAIL mid_pattern_prefix: state=%0d, want %0d", u_ov.state_q, S3);
    end
    #1;
    reset = 1'b0;
    h_ov.delete();
    h_no.delete();
    #1;
    vectors++;
    if (u_ov.state_q !== S0 || u_no.state_q !== S0 || out_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clear: st_ov=%0d st_no=%0d out=%b, want 0 0 0",
               u_ov.state_q, u_no.state_q, out_ov);
    end
    #1;
    reset = 1'b1;
    apply_bit(1'b0, e_ov, e_no, s_ov, s_no);
    vectors++;
    if (out_ov !== 1'b0 || out_no !== 1'b0 || u_ov.state_q !== s_ov || e_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_zero: out_ov=%b out_no=%b state=%0d, want 0 0 %0d",
               out_ov, out_no, u_ov.state_q, s_ov);
    end
  endtask

  task automatic test_back_to_back();
    bit seq[$] = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit want_ov[$] = '{0, 0, 0, 1, 0, 1, 0, 1};
    bit want_no[$] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit e_ov, e_no;
    state_e s_ov, s_no;
    do_reset();
    foreach (seq[i]) begin
      apply_bit(seq[i], e_ov, e_no, s_ov, s_no);
      vectors++;
      if (out_ov !== want_ov[i] || out_ov !== e_ov) begin
        miscompares++;
        $display("FAIL back_to_back_ov sample %0d: out=%b, want %b", i + 1, out_ov, want_ov[i]);
      end
      vectors++;
      if (out_no !== want_no[i] || out_no !== e_no) begin
        miscompares++;
        $display("FAIL back_to_back_no sample %0d: out=%b, want %b", i + 1, out_no, want_no[i]);
      end
    end
  endtask

  task automatic test_random();
    bit e_ov, e_no;
    bit prev_ov;
    state_e s_ov, s_no;
    do_reset();
    prev_ov = 1'b0;
    for (int n = 0; n < 400; n++) begin
      apply_bit(1'($urandom_range(0, 1)), e_ov, e_no, s_ov, s_no);
      vectors++;
      if (out_ov !== e_ov || u_ov.state_q !== s_ov) begin
        miscompares++;
        $display("FAIL random_ov bit %0d: out=%b state=%0d, want out=%b state=%0d",
                 n, out_ov, u_ov.state_q, e_ov, s_ov);
      end
      vectors++;
      if (out_no !== e_no || u_no.state_q !== s_no) begin
        miscompares++;
        $display("FAIL random_no bit %0d: out=%b state=%0d, want out=%b state=%0d",
                 n, out_no, u_no.state_q, e_no, s_no);
      end
      vectors++;
      if (prev_ov === 1'b1 && out_ov !== 1'b0) begin
        miscompares++;
        $display("FAIL random_pulse_width bit %0d: out=%b, want 0", n, out_ov);
      end
      prev_ov = out_ov;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    in_bit      = 1'b0;
    test_reset();
    test_overlap_stream();
    test_near_miss();
    test_reset_mid_pattern();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
